fetch_stage: RTL and testbench

Instruction-fetch stage sitting directly upstream of the instruction memory. It holds the program counter, drives the 6-bit word address into the combinational instruction ROM, and captures the returned word into an IF/ID pipeline register with a valid/ready handshake toward decode. It also handles branch/jump redirects from execute, a halt request, and a sticky fault for misaligned or out-of-range fetch addresses.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/if_id_reg.sv | 37 +++
 rtl/fetch_stage.sv | 103 ++++++++++
 tb/tb_fetch_stage.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, reset vector, instruction width.
package cpu_pkg;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int unsigned INSTR_W          = 32;

   typedef enum logic [1:0] {RUN, HALT, FAULT} fetch_state_t;

   function automatic logic is_aligned(input logic [31:0] addr);
      return addr[1:0] == 2'b00;
   endfunction
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: valid/ready handshake with flush and load enable.
module if_id_reg
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               load,
   input  logic               ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [31:0]        in_pc,
   output logic               valid,
   output logic [INSTR_W-1:0] instr,
   output logic [31:0]        pc,
   output logic [31:0]        pc_plus4
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid    <= 1'b0;
         instr    <= '0;
         pc       <= '0;
         pc_plus4 <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid    <= 1'b1;
         instr    <= in_instr;
         pc       <= in_pc;
         pc_plus4 <= in_pc + 32'd4;
      end else if (ready) begin
         // Consumed with nothing new behind it; payload is left as-is.
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, RUN/HALT/FAULT control, redirect handling, feeds if_id_reg.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned IMEM_AW  = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [INSTR_W-1:0] imem_instr,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   input  logic               halt_req,
   input  logic               id_ready,
   output logic               id_valid,
   output logic [INSTR_W-1:0] id_instr,
   output logic [31:0]        id_pc,
   output logic [31:0]        id_pc_plus4,
   output logic               halted,
   output logic               fault
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         pc_in_range, redirect_ok, slot_free;
   logic         load, flush;

   assign imem_addr   = pc_q[IMEM_AW+1:2];
   assign pc_in_range = (pc_q >> (IMEM_AW + 2)) == 32'd0;
   assign redirect_ok = is_aligned(redirect_pc) && ((redirect_pc >> (IMEM_AW + 2)) == 32'd0);
   assign slot_free   = !id_valid || id_ready;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      load    = 1'b0;
      flush   = 1'b0;
      unique case (state_q)
         RUN: begin
            if (redirect_valid) begin
               flush = 1'b1;
               if (!redirect_ok) begin
                  state_d = FAULT;
               end else begin
                  pc_d = redirect_pc;
                  if (halt_req) state_d = HALT;
               end
            end else if (!pc_in_range) begin
               state_d = FAULT;
            end else begin
               if (slot_free) begin
                  load = 1'b1;
                  pc_d = pc_q + 32'd4;
               end
               if (halt_req) state_d = HALT;
            end
         end
         HALT: begin
            if (redirect_valid) begin
               flush = 1'b1;
               if (redirect_ok) begin
                  pc_d    = redirect_pc;
                  state_d = RUN;
               end else begin
                  state_d = FAULT;
               end
            end
         end
         FAULT: flush = 1'b1;
         default: state_d = FAULT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         halted  <= 1'b0;
         fault   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         halted  <= (state_d == HALT);
         fault   <= (state_d == FAULT);
      end
   end

   if_id_reg u_if_id_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .load     (load),
      .ready    (id_ready),
      .in_instr (imem_instr),
      .in_pc    (pc_q),
      .valid    (id_valid),
      .instr    (id_instr),
      .pc       (id_pc),
      .pc_plus4 (id_pc_plus4)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational ROM model.
module tb_fetch_stage;
   logic        clk;
   logic        rst_n;
   logic [5:0]  imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic        halted;
   logic        fault;

   logic [31:0] rom [64];
   int          checks;
   int          errors;

   assign imem_instr = rom[imem_addr];

   fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(6)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .id_ready       (id_ready),
      .id_valid       (id_valid),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_pc_plus4    (id_pc_plus4),
      .halted         (halted),
      .fault          (fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      halt_req       = 1'b0;
      id_ready       = 1'b1;
      rst_n          = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      halt_req       = 1'b0;
      id_ready       = 1'b1;
      rst_n          = 1'b0;
      #3;
      checks++;
      if ({id_valid, halted, fault} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got %b want 000", {id_valid, halted, fault});
      end
      checks++;
      if ({id_instr, id_pc, id_pc_plus4} !== 96'h0) begin
         errors++;
         $display("FAIL reset_data got %h %h %h want 0", id_instr, id_pc, id_pc_plus4);
      end
      checks++;
      if (imem_addr !== 6'd0) begin
         errors++;
         $display("FAIL reset_addr got %0d want 0", imem_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_stream();
      logic [31:0] exp_i;
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_i = 32'h11 * (i + 1);
         checks++;
         if (id_valid !== 1'b1 || id_pc !== 32'(i * 4) || id_instr !== exp_i
             || id_pc_plus4 !== 32'(i * 4 + 4)) begin
            errors++;
            $display("FAIL stream%0d got v=%b pc=%h ins=%h p4=%h want pc=%h ins=%h", i,
                     id_valid, id_pc, id_instr, id_pc_plus4, 32'(i * 4), exp_i);
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      tick();
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (id_valid !== 1'b1 || id_instr !== 32'h11 || id_pc !== 32'h0 || imem_addr !== 6'd1)
         begin
            errors++;
            $display("FAIL stall_hold%0d got v=%b ins=%h pc=%h addr=%0d want 1 11 0 1", i,
                     id_valid, id_instr, id_pc, imem_addr);
         end
      end
      id_ready = 1'b1;
      tick();
      checks++;
      if (id_pc !== 32'h4 || id_instr !== 32'h22) begin
         errors++;
         $display("FAIL stall_release got pc=%h ins=%h want 4 22", id_pc, id_instr);
      end
   endtask

   task automatic test_redirect_stalled();
      do_reset();
      tick();
      id_ready       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      tick();
      checks++;
      if (id_valid !== 1'b0 || imem_addr !== 6'd16) begin
         errors++;
         $display("FAIL redir_bubble got v=%b addr=%0d want 0 16", id_valid, imem_addr);
      end
      redirect_valid = 1'b0;
      id_ready       = 1'b1;
      tick();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== 32'hA000_0010
          || id_pc_plus4 !== 32'h44) begin
         errors++;
         $display("FAIL redir_target got v=%b pc=%h ins=%h p4=%h want 1 40 a0000010 44",
                  id_valid, id_pc, id_instr, id_pc_plus4);
      end
   endtask

   task automatic test_halt();
      do_reset();
      tick();
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      checks++;
      if (halted !== 1'b1 || id_valid !== 1'b1 || id_pc !== 32'h4) begin
         errors++;
         $display("FAIL halt_enter got h=%b v=%b pc=%h want 1 1 4", halted, id_valid, id_pc);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (halted !== 1'b1 || id_valid !== 1'b0 || imem_addr !== 6'd2) begin
            errors++;
            $display("FAIL halt_idle%0d got h=%b v=%b addr=%0d want 1 0 2", i, halted,
                     id_valid, imem_addr);
         end
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (halted !== 1'b0 || id_valid !== 1'b0) begin
         errors++;
         $display("FAIL halt_resume got h=%b v=%b want 0 0", halted, id_valid);
      end
      tick();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_instr !== 32'h33) begin
         errors++;
         $display("FAIL halt_refetch got v=%b pc=%h ins=%h want 1 8 33", id_valid, id_pc,
                  id_instr);
      end
   endtask

   task automatic test_fault_misaligned();
      do_reset();
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h6;
      tick();
      checks++;
      if (fault !== 1'b1 || id_valid !== 1'b0 || imem_addr !== 6'd1) begin
         errors++;
         $display("FAIL misalign got f=%b v=%b addr=%0d want 1 0 1", fault, id_valid,
                  imem_addr);
      end
      redirect_pc = 32'h10;
      tick();
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (fault !== 1'b1 || id_valid !== 1'b0 || imem_addr !== 6'd1) begin
         errors++;
         $display("FAIL misalign_sticky got f=%b v=%b addr=%0d want 1 0 1", fault, id_valid,
                  imem_addr);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (fault !== 1'b0 || imem_addr !== 6'd0 || id_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got f=%b addr=%0d v=%b want 0 0 0", fault, imem_addr,
                  id_valid);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_fault_overflow();
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hF8;
      tick();
      redirect_valid = 1'b0;
      tick();
      tick();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'hFC || id_instr !== 32'hA000_003F
          || fault !== 1'b0) begin
         errors++;
         $display("FAIL top_word got v=%b pc=%h ins=%h f=%b want 1 fc a000003f 0", id_valid,
                  id_pc, id_instr, fault);
      end
      tick();
      checks++;
      if (fault !== 1'b1 || id_valid !== 1'b0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL overflow got f=%b v=%b h=%b want 1 0 0", fault, id_valid, halted);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      tick();
      redirect_valid = 1'b0;
      tick();
      checks++;
      if (fault !== 1'b1 || id_valid !== 1'b0) begin
         errors++;
         $display("FAIL overflow_sticky got f=%b v=%b want 1 0", fault, id_valid);
      end
   endtask

   task automatic test_redirect_halt_same();
      do_reset();
      tick();
      redirect_valid = 1'b1;
      halt_req       = 1'b1;
      redirect_pc    = 32'h20;
      tick();
      redirect_valid = 1'b0;
      halt_req       = 1'b0;
      checks++;
      if (halted !== 1'b1 || id_valid !== 1'b0 || imem_addr !== 6'd8) begin
         errors++;
         $display("FAIL redir_halt got h=%b v=%b addr=%0d want 1 0 8", halted, id_valid,
                  imem_addr);
      end
      tick();
      tick();
      checks++;
      if (halted !== 1'b1 || id_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_halt_idle got h=%b v=%b want 1 0", halted, id_valid);
      end
      redirect_valid = 1'b1;
      tick();
      redirect_valid = 1'b0;
      tick();
      checks++;
      if (halted !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h20
          || id_instr !== 32'hA000_0008) begin
         errors++;
         $display("FAIL redir_halt_resume got h=%b v=%b pc=%h ins=%h want 0 1 20 a0000008",
                  halted, id_valid, id_pc, id_instr);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 | 32'(i);
      rom[0] = 32'h11;
      rom[1] = 32'h22;
      rom[2] = 32'h33;
      rom[3] = 32'h44;
      test_reset();
      test_stream();
      test_stall();
      test_redirect_stalled();
      test_halt();
      test_fault_misaligned();
      test_fault_overflow();
      test_redirect_halt_same();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
